counter_burst_arbiter: RTL and testbench

//  Round-robin scheduler that shares one up/down counter (tb_counter-style datapath,

---
 rtl/counter_burst_arbiter.sv | 176 +++++++++++++++++
 tb/tb_counter_burst_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_burst_arbiter.sv
// rtl/counter_burst_arbiter.sv - round-robin burst scheduler sharing one saturating up/down counter
//
// Purpose:
//   Grants one of NREQ requesters at a time a counting burst of req_len steps on an
//   external up/down counter. Bursts stop at 0 / all-ones instead of wrapping. A clear
//   command is served ahead of any pending burst request.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   req       in   [NREQ]        level burst request per requester
//   req_up    in   [NREQ]        direction per requester (1 = up, 0 = down)
//   req_len   in   [NREQ*LEN_W]  burst length per requester, slice i = [i*LEN_W +: LEN_W]
//   clr_req   in   request to zero the counter
//   cnt_val   in   [WIDTH]       current counter value
//   cnt_mode  out  counter direction (holds last burst direction when idle)
//   cnt_en    out  counter step enable
//   cnt_rst   out  counter synchronous clear
//   gnt       out  [NREQ]        one-hot grant, high for the whole burst
//   done      out  [NREQ]        one-cycle completion pulse to the granted requester
//   done_sat  out  valid with done: burst stopped early on a boundary
//   clr_ack   out  one-cycle pulse, counter cleared on this edge
//   busy      out  scheduler not idle

module counter_burst_arbiter #(
    parameter int WIDTH = 10,
    parameter int NREQ  = 2,
    parameter int LEN_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_up,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    input  logic                    clr_req,
    input  logic [WIDTH-1:0]        cnt_val,
    output logic                    cnt_mode,
    output logic                    cnt_en,
    output logic                    cnt_rst,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    done_sat,
    output logic                    clr_ack,
    output logic                    busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic               dir;
    logic               sat;
    logic [LEN_W-1:0]   rem;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               rem_zero;
    logic               blocked;

    // (base + off) mod NREQ, with base, off < NREQ
    function automatic logic [IDX_W-1:0] rr_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= (IDX_W+1)'(NREQ)) begin
            s = s - (IDX_W+1)'(NREQ);
        end
        return s[IDX_W-1:0];
    endfunction

    // Round-robin pick: scan offsets from the far end so the smallest offset
    // from rr_ptr that has a request is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_add(rr_ptr, IDX_W'(k))]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_add(rr_ptr, IDX_W'(k));
            end
        end
    end

    assign rem_zero = (rem == '0);
    // Stepping further in the current direction would wrap the counter.
    assign blocked  = dir ? (cnt_val == {WIDTH{1'b1}}) : (cnt_val == '0);

    // State register and burst context
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            idx    <= '0;
            dir    <= 1'b0;
            sat    <= 1'b0;
            rem    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (!clr_req && pick_valid) begin
                        idx <= pick_idx;
                        dir <= req_up[pick_idx];
                        rem <= req_len[int'(pick_idx)*LEN_W +: LEN_W];
                        sat <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!rem_zero && !blocked) begin
                        rem <= rem - 1'b1;
                    end else begin
                        // Leaving RUN with steps left means a boundary stopped us.
                        sat <= !rem_zero;
                    end
                end
                S_DONE: begin
                    rr_ptr <= rr_add(idx, IDX_W'(1));
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr_req) begin
                    state_nxt = S_CLR;
                end else if (pick_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_CLR:  state_nxt = S_IDLE;
            S_RUN: begin
                if (rem_zero || blocked) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt  = '0;
        done = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]  = (state == S_RUN)  && (idx == IDX_W'(i));
            done[i] = (state == S_DONE) && (idx == IDX_W'(i));
        end
        cnt_mode = dir;
        // Gated by rst so enable and clear are never asserted together.
        cnt_en   = (state == S_RUN) && !rem_zero && !blocked && !rst;
        cnt_rst  = rst || (state == S_CLR);
        clr_ack  = (state == S_CLR);
        done_sat = (state == S_DONE) && sat;
        busy     = (state != S_IDLE);
    end

    a_en_rst_excl: assert property (@(posedge clk) !(cnt_en && cnt_rst));
    a_gnt_onehot:  assert property (@(posedge clk) $onehot0(gnt));
    a_done_onehot: assert property (@(posedge clk) $onehot0(done));

endmodule

// File: tb/tb_counter_burst_arbiter.sv
// tb/tb_counter_burst_arbiter.sv - self-checking bench for counter_burst_arbiter
module tb_counter_burst_arbiter;

    localparam int WIDTH = 10;
    localparam int NREQ  = 2;
    localparam int LEN_W = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_up;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic                   clr_req;
    logic [WIDTH-1:0]       cnt_val;
    logic                   cnt_mode;
    logic                   cnt_en;
    logic                   cnt_rst;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   done_sat;
    logic                   clr_ack;
    logic                   busy;

    logic                   preset_en;
    logic [WIDTH-1:0]       preset_val;

    always #5 clk = ~clk;

    counter_burst_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_up   (req_up),
        .req_len  (req_len),
        .clr_req  (clr_req),
        .cnt_val  (cnt_val),
        .cnt_mode (cnt_mode),
        .cnt_en   (cnt_en),
        .cnt_rst  (cnt_rst),
        .gnt      (gnt),
        .done     (done),
        .done_sat (done_sat),
        .clr_ack  (clr_ack),
        .busy     (busy)
    );

    // The shared counter datapath (wraps freely; the scheduler must keep it from wrapping).
    // preset_en lets the bench load a value while the scheduler is idle.
    always @(posedge clk) begin
        if (cnt_rst)        cnt_val <= '0;
        else if (preset_en) cnt_val <= preset_val;
        else if (cnt_en)    cnt_val <= cnt_mode ? cnt_val + 1'b1 : cnt_val - 1'b1;
    end

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] done;
        logic            done_sat;
        logic            clr_ack;
        logic            cnt_en;
        logic            cnt_rst;
        logic            cnt_mode;
        logic            busy;
    } obs_t;

    // Model: per-cycle expectations of the transaction in flight; empty = idle.
    obs_t   sched[$];
    int     rr_m;
    logic   dir_m;
    int     cnt_m;
    bit     prev_rst;

    int     checks = 0;
    int     errors = 0;

    // Observation counters for the literal checks
    int     cycle_no = 0;
    int     n_gnt0, n_en, n_done, n_clr, clr_cycle, first_gnt_cycle;
    logic   last_sat;
    logic [NREQ-1:0] prev_gnt = '0;
    int     order[$];

    function automatic obs_t sample();
        obs_t o;
        o.gnt      = gnt;
        o.done     = done;
        o.done_sat = done_sat;
        o.clr_ack  = clr_ack;
        o.cnt_en   = cnt_en;
        o.cnt_rst  = cnt_rst;
        o.cnt_mode = cnt_mode;
        o.busy     = busy;
        return o;
    endfunction

    task automatic cmp_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got gnt=%b done=%b sat=%b ack=%b en=%b rst=%b mode=%b busy=%b, expected gnt=%b done=%b sat=%b ack=%b en=%b rst=%b mode=%b busy=%b",
                     name, cycle_no, act.gnt, act.done, act.done_sat, act.clr_ack, act.cnt_en,
                     act.cnt_rst, act.cnt_mode, act.busy, exp.gnt, exp.done, exp.done_sat,
                     exp.clr_ack, exp.cnt_en, exp.cnt_rst, exp.cnt_mode, exp.busy);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Plan a whole burst from the rules: winner by round-robin, steps limited by
    // the room left before the boundary, one extra RUN cycle, one DONE cycle.
    task automatic plan_burst();
        int   w;
        int   len;
        int   room;
        int   steps;
        logic d;
        obs_t e;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (rr_m + k) % NREQ;
            if (w < 0 && req[c]) w = c;
        end
        d     = req_up[w];
        len   = int'(req_len[w*LEN_W +: LEN_W]);
        room  = d ? (MAXV - cnt_m) : cnt_m;
        steps = (len < room) ? len : room;
        e = '0;
        e.gnt[w]   = 1'b1;
        e.busy     = 1'b1;
        e.cnt_mode = d;
        e.cnt_en   = 1'b1;
        repeat (steps) sched.push_back(e);
        e.cnt_en = 1'b0;
        sched.push_back(e);
        e.gnt       = '0;
        e.done[w]   = 1'b1;
        e.done_sat  = (steps < len);
        sched.push_back(e);
        cnt_m = d ? cnt_m + steps : cnt_m - steps;
        rr_m  = (w + 1) % NREQ;
        dir_m = d;
    endtask

    task automatic check_cycle();
        obs_t act;
        obs_t e;
        act = sample();
        if (rst) begin
            checks++;
            if (!(cnt_rst === 1'b1 && cnt_en === 1'b0)) begin
                errors++;
                $display("FAIL rst_pins cyc=%0d: got cnt_rst=%b cnt_en=%b expected 1 0", cycle_no, cnt_rst, cnt_en);
            end
            if (prev_rst) begin
                e = '0;
                e.cnt_rst = 1'b1;
                cmp_obs("in_reset", act, e);
            end
            sched.delete();
            rr_m = 0; dir_m = 1'b0; cnt_m = 0; prev_rst = 1'b1;
        end else begin
            prev_rst = 1'b0;
            if (sched.size() == 0) begin
                e = '0;
                e.cnt_mode = dir_m;
                cmp_obs("idle", act, e);
                checks++;
                if (cnt_val !== WIDTH'(cnt_m)) begin
                    errors++;
                    $display("FAIL cnt_val cyc=%0d: got %0d expected %0d", cycle_no, cnt_val, cnt_m);
                end
                if (preset_en) begin
                    cnt_m = int'(preset_val);
                end else if (clr_req) begin
                    e = '0;
                    e.clr_ack = 1'b1; e.cnt_rst = 1'b1; e.busy = 1'b1; e.cnt_mode = dir_m;
                    sched.push_back(e);
                    cnt_m = 0;
                end else if (req != '0) begin
                    plan_burst();
                end
            end else begin
                e = sched.pop_front();
                cmp_obs("burst", act, e);
            end
        end
        n_gnt0 += int'(gnt[0]);
        n_en   += int'(cnt_en);
        if (done != '0) begin n_done++; last_sat = done_sat; end
        if (clr_ack) begin n_clr++; clr_cycle = cycle_no; end
        if (gnt != '0 && prev_gnt == '0) begin
            order.push_back(gnt[1] ? 1 : 0);
            if (first_gnt_cycle < 0) first_gnt_cycle = cycle_no;
        end
        prev_gnt = gnt;
        cycle_no++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rst = 1'b0; req = '0; clr_req = 1'b0; preset_en = 1'b0;
    endtask

    task automatic reset_obs();
        n_gnt0 = 0; n_en = 0; n_done = 0; n_clr = 0; last_sat = 1'bx;
        clr_cycle = -1; first_gnt_cycle = -1;
        order.delete();
    endtask

    function automatic int order_at(input int k);
        return (k < order.size()) ? order[k] : -1;
    endfunction

    task automatic preset(input logic [WIDTH-1:0] v);
        clear_in();
        preset_en = 1'b1; preset_val = v;
        tick();
        preset_en = 1'b0;
    endtask

    task automatic burst(input int who, input logic up, input int len, input int run_ticks);
        clear_in();
        req = '0; req[who] = 1'b1;
        req_up = {NREQ{up}};
        req_len = {NREQ{LEN_W'(len)}};
        tick();
        req = '0;
        repeat (run_ticks) tick();
    endtask

    logic [31:0] r;

    initial begin
        clear_in();
        req_up = '0; req_len = '0; preset_val = '0;
        rr_m = 0; dir_m = 1'b0; cnt_m = 0; prev_rst = 1'b0;
        reset_obs();

        // 1: reset for three cycles
        rst = 1'b1;
        repeat (3) tick();
        clear_in();
        tick();
        check_int("reset_cnt_val", int'(cnt_val), 0);
        check_int("reset_busy", int'(busy), 0);

        // 2: up burst of 5 from 0
        reset_obs();
        burst(0, 1'b1, 5, 9);
        check_int("b5_gnt_cycles", n_gnt0, 6);
        check_int("b5_steps", n_en, 5);
        check_int("b5_done", n_done, 1);
        check_int("b5_sat", int'(last_sat), 0);
        check_int("b5_cnt", int'(cnt_val), 5);

        // 3: saturate at top, then at bottom
        preset(10'h3FC);
        reset_obs();
        burst(0, 1'b1, 7, 8);
        check_int("top_steps", n_en, 3);
        check_int("top_cnt", int'(cnt_val), 'h3FF);
        check_int("top_sat", int'(last_sat), 1);
        preset(10'd2);
        reset_obs();
        burst(0, 1'b0, 7, 8);
        check_int("bot_steps", n_en, 2);
        check_int("bot_cnt", int'(cnt_val), 0);
        check_int("bot_sat", int'(last_sat), 1);

        // 4: both requesting continuously alternate from rr_ptr=0
        rst = 1'b1; tick(); clear_in();
        reset_obs();
        req = 2'b11; req_up = 2'b11; req_len = {4'd1, 4'd1};
        repeat (16) tick();
        clear_in();
        repeat (2) tick();
        check_int("rr_count", order.size(), 4);
        check_int("rr_0", order_at(0), 0);
        check_int("rr_1", order_at(1), 1);
        check_int("rr_2", order_at(2), 0);
        check_int("rr_3", order_at(3), 1);

        // 5: clear and request together -> clear first
        preset(10'd7);
        reset_obs();
        clr_req = 1'b1; req = 2'b01; req_up = 2'b01; req_len = {4'd0, 4'd2};
        tick();
        clr_req = 1'b0;
        tick();
        check_int("clr_cnt", int'(cnt_val), 0);
        tick();
        req = '0;
        repeat (5) tick();
        check_int("clr_acks", n_clr, 1);
        check_int("clr_to_gnt", first_gnt_cycle - clr_cycle, 2);
        check_int("clr_then_gnt0", order_at(0), 0);
        check_int("clr_after_cnt", int'(cnt_val), 2);

        // 6: reset mid-burst after rr_ptr has moved to 1
        burst(0, 1'b1, 1, 4);
        reset_obs();
        burst(0, 1'b1, 10, 3);
        rst = 1'b1;
        tick();
        clear_in();
        check_int("abort_gnt", int'(gnt), 0);
        tick();
        check_int("abort_no_done", n_done, 0);
        reset_obs();
        req = 2'b11; req_up = 2'b11; req_len = {4'd1, 4'd1};
        tick();
        clear_in();
        repeat (4) tick();
        check_int("abort_rr_first", order_at(0), 0);

        // Randomized traffic with boundary presets and occasional resets
        rst = 1'b1; tick(); clear_in();
        for (int i = 0; i < 3000; i++) begin
            clear_in();
            r = $urandom;
            if (r[7:0] == 8'd0) begin
                rst = 1'b1;
            end else if (sched.size() == 0 && r[10:8] == 3'd0) begin
                preset_en = 1'b1;
                case (r[13:11])
                    3'd0:    preset_val = '0;
                    3'd1:    preset_val = WIDTH'(r[17:14] & 4'h7);
                    3'd2:    preset_val = WIDTH'(MAXV);
                    3'd3:    preset_val = WIDTH'(MAXV) - WIDTH'(r[17:14] & 4'h7);
                    default: preset_val = r[WIDTH+13:14];
                endcase
            end else begin
                r = $urandom;
                req     = r[NREQ-1:0];
                req_up  = r[2*NREQ-1:NREQ];
                req_len = r[2*NREQ+NREQ*LEN_W-1:2*NREQ];
                clr_req = (r[31:28] == 4'd0);
            end
            tick();
        end
        clear_in();
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
